// File: rtl/timer_nbit_multi_oc.sv
// WIDTH-bit timer with an ATMega-style prescaler, NUM_OC output-compare channels and normal/CTC modes.
// Optional macro TIMER_OCR_BUFFER_EN: OCR writes are buffered and reach the compare logic when the count returns to 0.
module timer_nbit_multi_oc #(
    parameter int WIDTH  = 16,
    parameter int NUM_OC = 2,
    parameter int SEL_W  = 2
) (
    input  logic                    sysClock,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        TCNT_input,
    input  logic                    TCNT_write_enable,
    input  logic                    clear_count,
    input  logic [WIDTH-1:0]        OCR_input,
    input  logic [SEL_W-1:0]        OCR_sel,
    input  logic                    OCR_write_enable,
    input  logic [7:0]              TCCR_input,
    input  logic                    TCCR_write_enable,
    input  logic [NUM_OC:0]         TIMSK_input,
    input  logic                    TIMSK_write_enable,
    input  logic [NUM_OC:0]         TIFR_input,
    input  logic                    TIFR_write_enable,
    output logic [WIDTH-1:0]        TCNT_output,
    output logic [7:0]              TCCR_output,
    output logic [NUM_OC*WIDTH-1:0] OCR_output,
    output logic [NUM_OC:0]         TIMSK_output,
    output logic [NUM_OC:0]         TIFR_output,
    output logic [NUM_OC:0]         irq
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0]  tcnt_q, tcnt_d;
    logic [7:0]        tccr_q, tccr_d;
    logic [NUM_OC:0]   timsk_q, timsk_d;
    logic [NUM_OC:0]   tifr_q, tifr_d;
    logic [9:0]        presc_q, presc_d;
    logic [9:0]        presc_mask;
    logic              running;
    logic              tick;
    logic [NUM_OC-1:0] cmp_hit;
    logic [NUM_OC-1:0] ocr_sel_hit;
    logic              cmp_en;
    logic              tov_set;
    logic              zero_by_tick;

    // A tick fires when the low log2(div) prescaler bits are all ones.
    always_comb begin
        presc_mask = 10'h000;
        running    = 1'b1;
        case (tccr_q[2:0])
            3'd1:    presc_mask = 10'h000;
            3'd2:    presc_mask = 10'h007;
            3'd3:    presc_mask = 10'h03F;
            3'd4:    presc_mask = 10'h0FF;
            3'd5:    presc_mask = 10'h3FF;
            default: running    = 1'b0;
        endcase
    end

    assign tick    = running && ((presc_q & presc_mask) == presc_mask);
    assign presc_d = TCCR_write_enable ? 10'd0 : presc_q + 10'd1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OC; gi++) begin : g_oc
            logic [WIDTH-1:0] act_q, act_d;

            assign ocr_sel_hit[gi] = OCR_write_enable && (int'(OCR_sel) == gi);
            assign cmp_hit[gi]     = (tcnt_q == act_q);
`ifdef TIMER_OCR_BUFFER_EN
            logic [WIDTH-1:0] buf_q, buf_d;

            assign buf_d = ocr_sel_hit[gi] ? OCR_input : buf_q;
            assign act_d = (!running || zero_by_tick) ? buf_d : act_q;
            assign OCR_output[gi*WIDTH +: WIDTH] = buf_q;

            always_ff @(posedge sysClock) begin
                if (rst) begin
                    buf_q <= '0;
                    act_q <= '0;
                end else begin
                    buf_q <= buf_d;
                    act_q <= act_d;
                end
            end
`else
            assign act_d = ocr_sel_hit[gi] ? OCR_input : act_q;
            assign OCR_output[gi*WIDTH +: WIDTH] = act_q;

            always_ff @(posedge sysClock) begin
                if (rst) begin
                    act_q <= '0;
                end else begin
                    act_q <= act_d;
                end
            end
`endif
        end
    endgenerate

    // Explicit clears and loads outrank the tick and also mask that cycle's compare.
    always_comb begin
        tcnt_d       = tcnt_q;
        cmp_en       = 1'b0;
        tov_set      = 1'b0;
        zero_by_tick = 1'b0;
        if (clear_count) begin
            tcnt_d = '0;
        end else if (TCNT_write_enable) begin
            tcnt_d = TCNT_input;
        end else if (tick) begin
            cmp_en = 1'b1;
            if (tccr_q[3] && cmp_hit[0]) begin
                tcnt_d       = '0;
                zero_by_tick = 1'b1;
            end else begin
                tcnt_d = tcnt_q + WIDTH'(1);
                if (tcnt_q == ALL_ONES) begin
                    tov_set      = 1'b1;
                    zero_by_tick = 1'b1;
                end
            end
        end
    end

    // Hardware sets are applied after the software clear so a coincident set survives.
    always_comb begin
        tifr_d = tifr_q;
        if (TIFR_write_enable) begin
            tifr_d = tifr_q & ~TIFR_input;
        end
        if (cmp_en) begin
            tifr_d[NUM_OC:1] = tifr_d[NUM_OC:1] | cmp_hit;
        end
        if (tov_set) begin
            tifr_d[0] = 1'b1;
        end
    end

    assign tccr_d  = TCCR_write_enable  ? TCCR_input  : tccr_q;
    assign timsk_d = TIMSK_write_enable ? TIMSK_input : timsk_q;

    always_ff @(posedge sysClock) begin
        if (rst) begin
            tcnt_q  <= '0;
            tccr_q  <= '0;
            timsk_q <= '0;
            tifr_q  <= '0;
            presc_q <= '0;
        end else begin
            tcnt_q  <= tcnt_d;
            tccr_q  <= tccr_d;
            timsk_q <= timsk_d;
            tifr_q  <= tifr_d;
            presc_q <= presc_d;
        end
    end

    assign TCNT_output  = tcnt_q;
    assign TCCR_output  = tccr_q;
    assign TIMSK_output = timsk_q;
    assign TIFR_output  = tifr_q;
    assign irq          = tifr_q & timsk_q;

endmodule

// File: tb/tb_timer_nbit_multi_oc.sv
// Scoreboard bench for timer_nbit_multi_oc (WIDTH=16, NUM_OC=2): directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model; honours TIMER_OCR_BUFFER_EN when defined.
module tb_timer_nbit_multi_oc;

    typedef struct packed {
        logic [15:0] tcnt;
        logic [7:0]  tccr;
        logic [31:0] ocr;
        logic [2:0]  timsk;
        logic [2:0]  tifr;
        logic [2:0]  irq;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] TCNT_input;
    logic        TCNT_write_enable;
    logic        clear_count;
    logic [15:0] OCR_input;
    logic [1:0]  OCR_sel;
    logic        OCR_write_enable;
    logic [7:0]  TCCR_input;
    logic        TCCR_write_enable;
    logic [2:0]  TIMSK_input;
    logic        TIMSK_write_enable;
    logic [2:0]  TIFR_input;
    logic        TIFR_write_enable;
    logic [15:0] TCNT_output;
    logic [7:0]  TCCR_output;
    logic [31:0] OCR_output;
    logic [2:0]  TIMSK_output;
    logic [2:0]  TIFR_output;
    logic [2:0]  irq;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state (plain integers)
    int m_cnt, m_tccr, m_timsk, m_tifr, m_phase;
    int m_ocr[2];
    int m_buf[2];

    timer_nbit_multi_oc #(.WIDTH(16), .NUM_OC(2), .SEL_W(2)) dut (
        .sysClock(clk),
        .rst(rst),
        .TCNT_input(TCNT_input),
        .TCNT_write_enable(TCNT_write_enable),
        .clear_count(clear_count),
        .OCR_input(OCR_input),
        .OCR_sel(OCR_sel),
        .OCR_write_enable(OCR_write_enable),
        .TCCR_input(TCCR_input),
        .TCCR_write_enable(TCCR_write_enable),
        .TIMSK_input(TIMSK_input),
        .TIMSK_write_enable(TIMSK_write_enable),
        .TIFR_input(TIFR_input),
        .TIFR_write_enable(TIFR_write_enable),
        .TCNT_output(TCNT_output),
        .TCCR_output(TCCR_output),
        .OCR_output(OCR_output),
        .TIMSK_output(TIMSK_output),
        .TIFR_output(TIFR_output),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 5000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int cs);
        case (cs)
            1: return 1;
            2: return 8;
            3: return 64;
            4: return 256;
            5: return 1024;
            default: return 0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int d, nc, set, sel;
        bit tick, to_zero;
        if (rst) begin
            m_cnt = 0; m_tccr = 0; m_timsk = 0; m_tifr = 0; m_phase = 0;
            m_ocr[0] = 0; m_ocr[1] = 0; m_buf[0] = 0; m_buf[1] = 0;
            return;
        end
        d       = div_of(m_tccr % 8);
        tick    = (d != 0) && ((m_phase % d) == d - 1);
        set     = 0;
        to_zero = 0;
        nc      = m_cnt;
        if (clear_count) begin
            nc = 0;
        end else if (TCNT_write_enable) begin
            nc = int'(TCNT_input);
        end else if (tick) begin
            for (int n = 0; n < 2; n++)
                if (m_cnt == m_ocr[n]) set = set | (2 << n);
            if (((m_tccr / 8) % 2 == 1) && (m_cnt == m_ocr[0])) begin
                nc      = 0;
                to_zero = 1;
            end else begin
                nc = (m_cnt + 1) % 65536;
                if (nc == 0) begin
                    set     = set | 1;
                    to_zero = 1;
                end
            end
        end
        if (TIFR_write_enable) m_tifr = m_tifr & ~int'(TIFR_input);
        m_tifr = (m_tifr | set) % 8;
        sel = int'(OCR_sel);
`ifdef TIMER_OCR_BUFFER_EN
        if (OCR_write_enable && sel < 2) m_buf[sel] = int'(OCR_input);
        if (d == 0 || to_zero) begin
            m_ocr[0] = m_buf[0];
            m_ocr[1] = m_buf[1];
        end
`else
        if (OCR_write_enable && sel < 2) m_ocr[sel] = int'(OCR_input);
`endif
        m_cnt = nc;
        if (TCCR_write_enable)  m_tccr  = int'(TCCR_input);
        if (TIMSK_write_enable) m_timsk = int'(TIMSK_input);
        m_phase = TCCR_write_enable ? 0 : (m_phase + 1) % 1024;
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.tcnt  = 16'(m_cnt);
        e.tccr  = 8'(m_tccr);
`ifdef TIMER_OCR_BUFFER_EN
        e.ocr   = {16'(m_buf[1]), 16'(m_buf[0])};
`else
        e.ocr   = {16'(m_ocr[1]), 16'(m_ocr[0])};
`endif
        e.timsk = 3'(m_timsk);
        e.tifr  = 3'(m_tifr);
        e.irq   = 3'(m_tifr & m_timsk);
        return e;
    endfunction

    // Monitor: each clock edge produces one expected register snapshot.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_tcnt",  32'(TCNT_output),  32'(mon_e.tcnt));
            chk("sb_tccr",  32'(TCCR_output),  32'(mon_e.tccr));
            chk("sb_ocr",   OCR_output,        mon_e.ocr);
            chk("sb_timsk", 32'(TIMSK_output), 32'(mon_e.timsk));
            chk("sb_tifr",  32'(TIFR_output),  32'(mon_e.tifr));
            chk("sb_irq",   32'(irq),          32'(mon_e.irq));
        end
    end

    task automatic step();
        model_step();
        exp_q.push_back(model_exp());
        @(negedge clk);
        TCNT_write_enable  = 1'b0;
        clear_count        = 1'b0;
        OCR_write_enable   = 1'b0;
        TCCR_write_enable  = 1'b0;
        TIMSK_write_enable = 1'b0;
        TIFR_write_enable  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr_tccr(input logic [7:0] v);
        TCCR_input = v; TCCR_write_enable = 1'b1;
        $display("[%0t] write TCCR=0x%02h", $time, v);
        step();
    endtask

    task automatic wr_tcnt(input logic [15:0] v);
        TCNT_input = v; TCNT_write_enable = 1'b1;
        $display("[%0t] write TCNT=0x%04h", $time, v);
        step();
    endtask

    task automatic wr_ocr(input logic [1:0] s, input logic [15:0] v);
        OCR_sel = s; OCR_input = v; OCR_write_enable = 1'b1;
        $display("[%0t] write OCR%0d=0x%04h", $time, s, v);
        step();
    endtask

    task automatic wr_timsk(input logic [2:0] v);
        TIMSK_input = v; TIMSK_write_enable = 1'b1;
        $display("[%0t] write TIMSK=0x%0h", $time, v);
        step();
    endtask

    task automatic wr_tifr(input logic [2:0] v);
        TIFR_input = v; TIFR_write_enable = 1'b1;
        $display("[%0t] write TIFR=0x%0h", $time, v);
        step();
    endtask

    task automatic wait_model_cnt(input int v);
        int i;
        i = 0;
        while (m_cnt != v && i < 20) begin
            step();
            i++;
        end
        chk("wait_cnt", 32'(m_cnt), 32'(v));
    endtask

    initial begin
        rst = 1'b1;
        TCNT_input = '0; TCNT_write_enable = 1'b0; clear_count = 1'b0;
        OCR_input = '0; OCR_sel = '0; OCR_write_enable = 1'b0;
        TCCR_input = '0; TCCR_write_enable = 1'b0;
        TIMSK_input = '0; TIMSK_write_enable = 1'b0;
        TIFR_input = '0; TIFR_write_enable = 1'b0;
        @(negedge clk);
        idle(2);
        rst = 1'b0;

        // 1: reset held mid-count
        wr_tccr(8'h01);
        wr_ocr(2'd1, 16'h0055);
        wr_timsk(3'h7);
        idle(5);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        chk("rst_tcnt",  32'(TCNT_output),  32'h0);
        chk("rst_tccr",  32'(TCCR_output),  32'h0);
        chk("rst_ocr",   OCR_output,        32'h0);
        chk("rst_timsk", 32'(TIMSK_output), 32'h0);
        chk("rst_tifr",  32'(TIFR_output),  32'h0);
        chk("rst_irq",   32'(irq),          32'h0);
        idle(3);
        chk("stopped_hold", 32'(TCNT_output), 32'h0);

        // 2: overflow and W1C
        wr_tcnt(16'hFFFE);
        wr_timsk(3'h1);
        wr_tccr(8'h01);
        idle(1);
        chk("ovf_ffff", 32'(TCNT_output), 32'hFFFF);
        chk("ovf_no_tov", 32'(TIFR_output[0]), 32'h0);
        idle(1);
        chk("ovf_wrap", 32'(TCNT_output), 32'h0);
        chk("ovf_tov", 32'(TIFR_output[0]), 32'h1);
        chk("ovf_irq", 32'(irq), 32'h1);
        wr_tifr(3'h1);
        chk("tov_w1c", 32'(TIFR_output[0]), 32'h0);
        wr_tccr(8'h00);

        // 3: clk/8 prescaler and phase restart on TCCR write
        wr_tcnt(16'h0000);
        wr_tccr(8'h02);
        idle(80);
        chk("div8_80", 32'(TCNT_output), 32'd10);
        idle(3);
        wr_tccr(8'h02);
        idle(7);
        chk("div8_restart", 32'(TCNT_output), 32'd10);
        idle(1);
        chk("div8_next", 32'(TCNT_output), 32'd11);

        // 4: CTC with OCR0=4, OCR1=2
        wr_tccr(8'h00);
        wr_tcnt(16'h0000);
        wr_ocr(2'd0, 16'd4);
        wr_ocr(2'd1, 16'd2);
        wr_tifr(3'h7);
        wr_tccr(8'h09);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("ctc_seq", 32'(TCNT_output), 32'(k % 5));
            chk("ctc_ocf0", 32'(TIFR_output[1]), 32'(k >= 5));
            chk("ctc_ocf1", 32'(TIFR_output[2]), 32'(k >= 3));
        end
        chk("ctc_no_tov", 32'(TIFR_output[0]), 32'h0);

        // 5: set beats clear; TCNT write suppresses compare
        wait_model_cnt(1);
        wr_tifr(3'h7);
        wait_model_cnt(4);
        wr_tifr(3'h2);
        chk("set_wins", 32'(TIFR_output[1]), 32'h1);
        wait_model_cnt(1);
        wr_tifr(3'h7);
        wait_model_cnt(4);
        wr_tcnt(16'd4);
        chk("wr_suppress", 32'(TIFR_output[1]), 32'h0);
        chk("wr_value", 32'(TCNT_output), 32'd4);
        idle(1);
        chk("cmp_after_wr", 32'(TIFR_output[1]), 32'h1);
        chk("ctc_clear", 32'(TCNT_output), 32'h0);

        // 6: OCR0 rewrite mid-period
        wr_tccr(8'h00);
        wr_tcnt(16'h0000);
        wr_ocr(2'd0, 16'd9);
        wr_tifr(3'h7);
        wr_tccr(8'h09);
        idle(5);
        chk("p6_at5", 32'(TCNT_output), 32'd5);
        wr_ocr(2'd0, 16'd3);
        idle(3);
        chk("p6_at9", 32'(TCNT_output), 32'd9);
        idle(1);
`ifdef TIMER_OCR_BUFFER_EN
        chk("p6_buf_clear", 32'(TCNT_output), 32'd0);
        idle(3);
        chk("p6_buf_top3", 32'(TCNT_output), 32'd3);
        idle(1);
        chk("p6_buf_wrap", 32'(TCNT_output), 32'd0);
        chk("p6_buf_no_tov", 32'(TIFR_output[0]), 32'h0);
`else
        chk("p6_pass9", 32'(TCNT_output), 32'd10);
        wr_tcnt(16'hFFFD);
        idle(2);
        chk("p6_ffff", 32'(TCNT_output), 32'hFFFF);
        idle(1);
        chk("p6_wrap", 32'(TCNT_output), 32'h0);
        chk("p6_tov", 32'(TIFR_output[0]), 32'h1);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom % 150 == 0);
            clear_count = ($urandom % 60 == 0);
            if ($urandom % 25 == 0) begin
                TCNT_write_enable = 1'b1;
                case ($urandom % 3)
                    0: TCNT_input = 16'($urandom);
                    1: TCNT_input = 16'hFFF0 | 16'($urandom % 16);
                    default: TCNT_input = 16'($urandom % 16);
                endcase
            end
            if ($urandom % 20 == 0) begin
                OCR_write_enable = 1'b1;
                OCR_sel = 2'($urandom % 4);
                OCR_input = ($urandom % 4 == 0) ? 16'($urandom) : 16'($urandom % 24);
            end
            if ($urandom % 40 == 0) begin
                TCCR_write_enable = 1'b1;
                TCCR_input = {4'($urandom), 1'($urandom),
                              ($urandom % 2 == 0) ? 3'(1 + $urandom % 2) : 3'($urandom)};
            end
            if ($urandom % 20 == 0) begin
                TIMSK_write_enable = 1'b1;
                TIMSK_input = 3'($urandom);
            end
            if ($urandom % 6 == 0) begin
                TIFR_write_enable = 1'b1;
                TIFR_input = 3'($urandom);
            end
            step();
            rst = 1'b0;
        end
        $display("[%0t] random phase complete: 800 cycles", $time);

        idle(2);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
